// File: rtl/bcd_seq_converter_pkg.sv
// bcd_pkg: shared types and helpers for the sequential binary-to-BCD converter.
//   state_t   : converter FSM states (IDLE, SHIFT)
//   BCD_NINE  : digit value used when saturating an out-of-range result
//   cnt_width : width of the bit counter, clog2(WIDTH+1), so it can hold WIDTH
package bcd_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam logic [3:0] BCD_NINE = 4'h9;

    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/bcd_seq_converter_if.sv
// bcd_seq_converter_if: start/busy/done handshake and data bus of the converter.
//   start    : request a conversion (master -> slave)
//   binary   : WIDTH-bit unsigned value, captured when start is accepted
//   busy     : conversion in progress (slave -> master)
//   done     : one-cycle pulse, bcd/overflow valid from this cycle on
//   bcd      : DIGITS packed BCD digits, ones digit in [3:0]
//   overflow : value exceeded 10^DIGITS-1, bcd saturated to all nines
interface bcd_seq_converter_if #(
    parameter int WIDTH  = 6,
    parameter int DIGITS = 2
);
    logic                  start;
    logic [WIDTH-1:0]      binary;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   bcd;
    logic                  overflow;

    modport master (output start, binary, input busy, done, bcd, overflow);
    modport slave  (input start, binary, output busy, done, bcd, overflow);
endinterface

// File: rtl/bcd_seq_converter_digit_adj.sv
// bcd_digit_adj: double-dabble digit correction, adds 3 when the digit is >= 5
// so the following left shift carries correctly into the next decimal digit.
//   i_digit : scratch BCD digit
//   o_digit : corrected digit (4-bit, no carry out)
module bcd_digit_adj (
    input  logic [3:0] i_digit,
    output logic [3:0] o_digit
);
    assign o_digit = (i_digit >= 4'd5) ? i_digit + 4'd3 : i_digit;
endmodule

// File: rtl/bcd_seq_converter.sv
// bcd_seq_converter: sequential binary-to-BCD converter, one input bit per clock
// (shift-and-add-3). Values above 10^DIGITS-1 saturate to all nines with overflow.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : slave side of bcd_seq_converter_if (start/binary in,
//           busy/done/bcd/overflow out, all outputs registered)
module bcd_seq_converter
    import bcd_pkg::*;
#(
    parameter int WIDTH  = 6,
    parameter int DIGITS = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    bcd_seq_converter_if.slave    bus
);
    localparam int CW = cnt_width(WIDTH);
    localparam int BW = 4 * DIGITS;

    if (WIDTH < 4 || WIDTH > 20 || DIGITS < 1 || DIGITS > 6) begin : g_bad_param
        $error("bcd_seq_converter: WIDTH must be 4..20 and DIGITS 1..6");
    end

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic [WIDTH-1:0] r_sr;
    logic [BW-1:0]   r_scr;
    logic            r_ovf_scr;
    logic            r_busy;
    logic            r_done;
    logic [BW-1:0]   r_bcd;
    logic            r_ovf;

    logic [BW-1:0]   w_adj;
    logic [BW-1:0]   w_scr_nxt;
    logic            w_ovf_nxt;

    for (genvar g = 0; g < DIGITS; g++) begin : g_dig
        bcd_digit_adj u_adj (
            .i_digit (r_scr[4*g +: 4]),
            .o_digit (w_adj[4*g +: 4])
        );
    end

    // {scratch, shift register} << 1; the bit falling off the top digit would
    // belong to digit DIGITS, so any 1 there means the value is out of range.
    assign w_scr_nxt = {w_adj[BW-2:0], r_sr[WIDTH-1]};
    assign w_ovf_nxt = r_ovf_scr | w_adj[BW-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_sr      <= '0;
            r_scr     <= '0;
            r_ovf_scr <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_bcd     <= '0;
            r_ovf     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_sr      <= bus.binary;
                        r_scr     <= '0;
                        r_ovf_scr <= 1'b0;
                        r_cnt     <= CW'(WIDTH);
                        r_busy    <= 1'b1;
                        r_state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    r_sr      <= {r_sr[WIDTH-2:0], 1'b0};
                    r_scr     <= w_scr_nxt;
                    r_ovf_scr <= w_ovf_nxt;
                    r_cnt     <= r_cnt - CW'(1);
                    // last input bit shifted in on this edge
                    if (r_cnt == CW'(1)) begin
                        r_bcd   <= w_ovf_nxt ? {DIGITS{BCD_NINE}} : w_scr_nxt;
                        r_ovf   <= w_ovf_nxt;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
    assign bus.bcd      = r_bcd;
    assign bus.overflow = r_ovf;

endmodule

// File: tb/tb_bcd_seq_converter.sv
// tb_bcd_seq_converter: scoreboard bench for three converter configurations
// (6b/2 digits, 8b/2 digits, 16b/5 digits). Stimulus pushes the expected
// result and its expected done time; a negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_bcd_seq_converter;

    typedef struct {
        logic [23:0] bcd;
        logic        ovf;
        time         t;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        st  [3];
    logic [15:0] bin [3];
    int          total = 0;
    int          bad   = 0;
    exp_t        q6[$], q8[$], q16[$];

    always #5 clk = ~clk;

    bcd_seq_converter_if #(.WIDTH(6),  .DIGITS(2)) if6  ();
    bcd_seq_converter_if #(.WIDTH(8),  .DIGITS(2)) if8  ();
    bcd_seq_converter_if #(.WIDTH(16), .DIGITS(5)) if16 ();

    assign if6.start   = st[0];
    assign if6.binary  = bin[0][5:0];
    assign if8.start   = st[1];
    assign if8.binary  = bin[1][7:0];
    assign if16.start  = st[2];
    assign if16.binary = bin[2];

    bcd_seq_converter #(.WIDTH(6),  .DIGITS(2)) u_dut6  (.clk(clk), .rst_n(rst_n), .bus(if6));
    bcd_seq_converter #(.WIDTH(8),  .DIGITS(2)) u_dut8  (.clk(clk), .rst_n(rst_n), .bus(if8));
    bcd_seq_converter #(.WIDTH(16), .DIGITS(5)) u_dut16 (.clk(clk), .rst_n(rst_n), .bus(if16));

    function automatic int wof(input int k);
        return (k == 0) ? 6 : (k == 1) ? 8 : 16;
    endfunction

    function automatic logic [23:0] dec2bcd(input int v);
        return 24'(((v / 10) << 4) | (v % 10));
    endfunction

    task automatic chk(input string name, input logic [23:0] got, input logic [23:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    // monitor side: pop and compare one expected result
    task automatic check_out(input int k, input logic [23:0] b, input logic o);
        exp_t e;
        bit   have;
        have = 0;
        case (k)
            0: if (q6.size()  > 0) begin e = q6.pop_front();  have = 1; end
            1: if (q8.size()  > 0) begin e = q8.pop_front();  have = 1; end
            default: if (q16.size() > 0) begin e = q16.pop_front(); have = 1; end
        endcase
        total++;
        if (!have) begin
            bad++;
            $display("FAIL unexpected_done dut%0d bcd=%h ovf=%b t=%0t", k, b, o, $time);
        end else if (b !== e.bcd || o !== e.ovf || $time != e.t) begin
            bad++;
            $display("FAIL result dut%0d got bcd=%h ovf=%b t=%0t want bcd=%h ovf=%b t=%0t",
                     k, b, o, $time, e.bcd, e.ovf, e.t);
        end
    endtask

    always @(negedge clk) begin
        if (if6.done)  check_out(0, {16'd0, if6.bcd},  if6.overflow);
        if (if8.done)  check_out(1, {16'd0, if8.bcd},  if8.overflow);
        if (if16.done) check_out(2, {4'd0,  if16.bcd}, if16.overflow);
    end

    // Call at a negedge; raises start and returns just after the accepting edge.
    task automatic issue(input int k, input int v, input logic [23:0] eb,
                         input logic eo, input bit push);
        exp_t e;
        st[k]  = 1'b1;
        bin[k] = 16'(v);
        @(posedge clk);
        e.bcd = eb;
        e.ovf = eo;
        e.t   = $time + wof(k) * 10 + 5;
        if (push) begin
            case (k)
                0: q6.push_back(e);
                1: q8.push_back(e);
                default: q16.push_back(e);
            endcase
        end
    endtask

    task automatic drain(input int k);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (((k == 0) ? q6.size() : (k == 1) ? q8.size() : q16.size()) != 0 && n < 200);
        chk($sformatf("drain_dut%0d", k),
            24'((k == 0) ? q6.size() : (k == 1) ? q8.size() : q16.size()), 24'd0);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int bcnt;
        for (int i = 0; i < 3; i++) begin
            st[i]  = 1'b0;
            bin[i] = '0;
        end
        repeat (3) @(negedge clk);
        chk("rst_busy",  {21'd0, if6.busy, if8.busy, if16.busy}, 24'd0);
        chk("rst_done",  {21'd0, if6.done, if8.done, if16.done}, 24'd0);
        chk("rst_bcd16", {4'd0, if16.bcd}, 24'd0);
        chk("rst_ovf",   {21'd0, if6.overflow, if8.overflow, if16.overflow}, 24'd0);
        rst_n = 1'b1;
        idle(2);

        // single conversion, busy length
        issue(0, 59, 24'h59, 1'b0, 1);
        bcnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i == 0) st[0] = 1'b0;
            if (if6.busy) bcnt++;
        end
        chk("busy_cycles", 24'(bcnt), 24'd6);
        drain(0);

        // back-to-back sweep with start held high
        for (int v = 0; v < 64; v++) begin
            issue(0, v, dec2bcd(v), 1'b0, 1);
            repeat (6) @(posedge clk);
            @(negedge clk);
        end
        st[0] = 1'b0;
        drain(0);

        // saturation on the 8-bit / 2-digit converter
        issue(1, 100, 24'h99, 1'b1, 1);
        @(negedge clk); st[1] = 1'b0;
        idle(10);
        issue(1, 255, 24'h99, 1'b1, 1);
        @(negedge clk); st[1] = 1'b0;
        idle(10);
        issue(1, 99, 24'h99, 1'b0, 1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i == 0) st[1] = 1'b0;
            if (i == 2) chk("hold_during_conv", {15'd0, if8.overflow, if8.bcd}, {15'd0, 1'b1, 8'h99});
        end
        drain(1);

        // start while busy is ignored
        issue(1, 77, 24'h77, 1'b0, 1);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (i == 0) st[1] = 1'b0;
            if (i == 2) begin st[1] = 1'b1; bin[1] = 16'd42; end
            if (i == 3) st[1] = 1'b0;
        end
        drain(1);
        issue(1, 0, 24'h00, 1'b0, 1);
        @(negedge clk); st[1] = 1'b0;
        drain(1);

        // reset mid-conversion (previous 6-bit result is 63, so bcd is nonzero)
        issue(0, 45, 24'h45, 1'b0, 0);
        @(negedge clk); st[0] = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("busy_before_rst", {23'd0, if6.busy}, 24'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", {23'd0, if6.busy}, 24'd0);
        chk("midrst_done", {23'd0, if6.done}, 24'd0);
        chk("midrst_bcd",  {16'd0, if6.bcd},  24'd0);
        chk("midrst_ovf",  {23'd0, if6.overflow}, 24'd0);
        idle(2);
        rst_n = 1'b1;
        idle(12);
        issue(0, 45, 24'h45, 1'b0, 1);
        @(negedge clk); st[0] = 1'b0;
        drain(0);

        // wide configuration
        issue(2, 65535, 24'h65535, 1'b0, 1);
        @(negedge clk); st[2] = 1'b0;
        drain(2);
        issue(2, 40960, 24'h40960, 1'b0, 1);
        @(negedge clk); st[2] = 1'b0;
        drain(2);
        issue(2, 10, 24'h00010, 1'b0, 1);
        @(negedge clk); st[2] = 1'b0;
        drain(2);

        idle(5);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout t=%0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
